hazard_scoreboard_ctrl: RTL and testbench

- Pipeline hazard controller for the 16-register, 5-stage core; sits beside the forwarding unit and decides stall, bubble and flush for IF/ID/EX.
- Detects load-use hazards, tracks in-flight writes of the multi-cycle unit (MCU: mul/div) in a per-register scoreboard, and sequences MCU start/done with a small FSM.
- Stretches branch-taken flushes over a programmable penalty.
- Forwarding still resolves all single-cycle EX/MEM/WB dependencies; this block handles only what forwarding cannot.

---
 rtl/hazard_scoreboard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and MCU scoreboard stalls,
// MCU start/done sequencing and multi-cycle branch flushes for IF/ID/EX.
module hazard_scoreboard_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_mcu,
  input  logic                   idex_memread,
  input  logic [REG_ADDR_W-1:0]  idex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mcu_done,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_bubble,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   mcu_start,
  output logic [REG_ADDR_W-1:0]  mcu_rd,
  output logic                   mcu_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NREG-1:0]        r_pending;
  logic [2:0]             r_flush_cnt;
  logic [REG_ADDR_W-1:0]  r_mcu_rd;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_load_use, w_raw, w_waw, w_struct, w_stall;
  logic w_flush, w_stall_eff, w_issue, w_retire;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Hazard detection: everything that forwarding cannot resolve
  assign w_load_use = id_valid & idex_memread & (idex_rd != '0) &
                      ((id_rs_used & (id_rs == idex_rd)) | (id_rt_used & (id_rt == idex_rd)));
  assign w_raw      = id_valid & ((id_rs_used & r_pending[id_rs]) | (id_rt_used & r_pending[id_rt]));
  assign w_waw      = id_valid & id_regwrite & r_pending[id_rd];
  assign w_struct   = id_valid & id_is_mcu & (r_state == S_BUSY);
  assign w_stall    = w_load_use | w_raw | w_waw | w_struct;

  // Flush dominates stall; reset forces the pipeline to free-run with no side effects
  assign w_flush     = ~reset & (ex_branch_taken | (r_flush_cnt != 3'd0));
  assign w_stall_eff = ~reset & w_stall & ~w_flush;
  assign w_issue     = ~reset & id_valid & id_is_mcu & ~w_stall & ~w_flush & (r_state == S_IDLE);
  assign w_retire    = (r_state == S_BUSY) & mcu_done;

  always_comb begin
    w_state_nxt = r_state;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    mcu_start   = 1'b0;
    if (w_flush) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (w_stall_eff) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
    case (r_state)
      S_IDLE: if (w_issue) begin
        w_state_nxt = S_BUSY;
        mcu_start   = 1'b1;
      end
      S_BUSY: if (mcu_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, scoreboard and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_flush_cnt <= 3'd0;
      r_mcu_rd    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (ex_branch_taken)
        r_flush_cnt <= FLUSH_LOAD;
      else if (r_flush_cnt != 3'd0)
        r_flush_cnt <= r_flush_cnt - 3'd1;
      if (w_issue) begin
        r_mcu_rd <= id_rd;
        if (id_rd != '0) r_pending[id_rd] <= 1'b1;
      end
      if (w_retire) r_pending[r_mcu_rd] <= 1'b0;
      if (w_stall_eff) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign mcu_busy     = ~reset & (r_state == S_BUSY);
  assign mcu_rd       = reset ? '0 : r_mcu_rd;
  assign stall_cycles = reset ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: one task per scenario with inline checks.
module tb_hazard_scoreboard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_is_mcu;
  logic [3:0] id_rs, id_rt, id_rd, idex_rd;
  logic       idex_memread, ex_branch_taken, mcu_done;

  logic        pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, mcu_start, mcu_busy;
  logic [3:0]  mcu_rd;
  logic [15:0] stall_cycles;

  logic        pc_write_2, ifid_write_2, idex_bubble_2, flush_ifid_2, flush_idex_2, mcu_start_2, mcu_busy_2;
  logic [3:0]  mcu_rd_2;
  logic [1:0]  stall_cycles_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(.REG_ADDR_W(4), .FLUSH_CYCLES(2), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_mcu(id_is_mcu), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken), .mcu_done(mcu_done), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .mcu_start(mcu_start), .mcu_rd(mcu_rd), .mcu_busy(mcu_busy),
    .stall_cycles(stall_cycles));

  hazard_scoreboard_ctrl #(.REG_ADDR_W(4), .FLUSH_CYCLES(1), .STALL_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_mcu(id_is_mcu), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken), .mcu_done(mcu_done), .pc_write(pc_write_2),
    .ifid_write(ifid_write_2), .idex_bubble(idex_bubble_2), .flush_ifid(flush_ifid_2),
    .flush_idex(flush_idex_2), .mcu_start(mcu_start_2), .mcu_rd(mcu_rd_2), .mcu_busy(mcu_busy_2),
    .stall_cycles(stall_cycles_2));

  task automatic idle_in();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_rd = 0;
    id_regwrite = 0; id_is_mcu = 0; idex_memread = 0; idex_rd = 0;
    ex_branch_taken = 0; mcu_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic set_load_use(input logic [3:0] r);
    id_valid = 1; id_rs = r; id_rs_used = 1; idex_memread = 1; idex_rd = r;
  endtask

  task automatic issue_mcu(input logic [3:0] rd);
    id_valid = 1; id_is_mcu = 1; id_regwrite = 1; id_rd = rd;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1;
    step();
    set_load_use(4'd5);
    ex_branch_taken = 1; id_is_mcu = 1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %0b exp 1", pc_write); end
    checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifid_write got %0b exp 1", ifid_write); end
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got %0b exp 0", idex_bubble); end
    checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b%0b exp 00", flush_ifid, flush_idex); end
    checks++; if (mcu_start !== 1'b0 || mcu_busy !== 1'b0) begin errors++; $display("FAIL rst_mcu got start=%0b busy=%0b exp 0 0", mcu_start, mcu_busy); end
    checks++; if (mcu_rd !== 4'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_regs got rd=%0d cnt=%0d exp 0 0", mcu_rd, stall_cycles); end
    idle_in();
    step();
    reset = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(4'd5);
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b exp 001", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL lu_cnt0 got %0d exp 0", stall_cycles); end
    step();
    idex_memread = 0;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++; $display("FAIL lu_release got %b exp 110", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", stall_cycles); end
    idex_memread = 1; id_rs_used = 0; id_rt = 4'd5; id_rt_used = 1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_rt got %0b exp 1", idex_bubble); end
    id_rt_used = 0;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_unused got %0b exp 0", idex_bubble); end
    id_rt_used = 1; id_valid = 0;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_novalid got %0b exp 0", idex_bubble); end
    idle_in();
    step();
  endtask

  task automatic test_mcu_raw();
    do_reset();
    issue_mcu(4'd7);
    #1;
    checks++; if (mcu_start !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL raw_issue got start=%0b pc=%0b exp 1 1", mcu_start, pc_write); end
    step();
    checks++; if (mcu_busy !== 1'b1 || mcu_rd !== 4'd7) begin errors++; $display("FAIL raw_busy got busy=%0b rd=%0d exp 1 7", mcu_busy, mcu_rd); end
    idle_in();
    id_valid = 1; id_regwrite = 1; id_rd = 4'd8; id_rt = 4'd7; id_rt_used = 1;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin errors++; $display("FAIL raw_stall1 got %b exp 001", {pc_write, ifid_write, idex_bubble}); end
    step();
    checks++; if (idex_bubble !== 1'b1 || mcu_start !== 1'b0) begin errors++; $display("FAIL raw_stall2 got bub=%0b start=%0b exp 1 0", idex_bubble, mcu_start); end
    step();
    mcu_done = 1;
    #1;
    checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL raw_done_cycle got pc=%0b bub=%0b exp 0 1", pc_write, idex_bubble); end
    step();
    mcu_done = 0;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++; $display("FAIL raw_release got %b exp 110", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (mcu_busy !== 1'b0 || stall_cycles !== 16'd3) begin errors++; $display("FAIL raw_after got busy=%0b cnt=%0d exp 0 3", mcu_busy, stall_cycles); end
    idle_in();
    step();
  endtask

  task automatic test_struct_waw();
    do_reset();
    issue_mcu(4'd3);
    step();
    issue_mcu(4'd9);
    #1;
    checks++; if (idex_bubble !== 1'b1 || mcu_start !== 1'b0) begin errors++; $display("FAIL st_stall got bub=%0b start=%0b exp 1 0", idex_bubble, mcu_start); end
    id_regwrite = 0; id_is_mcu = 0; id_rd = 4'd3; id_regwrite = 1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL waw_stall got %0b exp 1", idex_bubble); end
    id_rd = 4'd10;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL waw_other got %0b exp 0", idex_bubble); end
    issue_mcu(4'd9);
    step();
    mcu_done = 1;
    #1;
    checks++; if (idex_bubble !== 1'b1 || mcu_start !== 1'b0) begin errors++; $display("FAIL st_done_cycle got bub=%0b start=%0b exp 1 0", idex_bubble, mcu_start); end
    step();
    mcu_done = 0;
    #1;
    checks++; if (mcu_start !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL st_issue2 got start=%0b bub=%0b exp 1 0", mcu_start, idex_bubble); end
    step();
    checks++; if (mcu_busy !== 1'b1 || mcu_rd !== 4'd9) begin errors++; $display("FAIL st_busy2 got busy=%0b rd=%0d exp 1 9", mcu_busy, mcu_rd); end
    idle_in();
    id_valid = 1; id_rs = 4'd3; id_rs_used = 1;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL st_r3_cleared got %0b exp 0", idex_bubble); end
    idle_in();
    mcu_done = 1;
    step();
    idle_in();
  endtask

  task automatic test_flush();
    do_reset();
    set_load_use(4'd5);
    ex_branch_taken = 1;
    #1;
    checks++; if ({flush_ifid, flush_idex, idex_bubble, pc_write, ifid_write} !== 5'b11011) begin errors++; $display("FAIL fl_c0 got %b exp 11011", {flush_ifid, flush_idex, idex_bubble, pc_write, ifid_write}); end
    step();
    ex_branch_taken = 0;
    #1;
    checks++; if ({flush_ifid, flush_idex, idex_bubble} !== 3'b110) begin errors++; $display("FAIL fl_c1 got %b exp 110", {flush_ifid, flush_idex, idex_bubble}); end
    checks++; if (flush_ifid_2 !== 1'b0 || idex_bubble_2 !== 1'b1) begin errors++; $display("FAIL fl1_c1 got fl=%0b bub=%0b exp 0 1", flush_ifid_2, idex_bubble_2); end
    step();
    checks++; if ({flush_ifid, flush_idex, idex_bubble} !== 3'b001) begin errors++; $display("FAIL fl_c2 got %b exp 001", {flush_ifid, flush_idex, idex_bubble}); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", stall_cycles); end
    do_reset();
    issue_mcu(4'd6);
    ex_branch_taken = 1;
    #1;
    checks++; if (mcu_start !== 1'b0 || flush_idex !== 1'b1) begin errors++; $display("FAIL fl_nostart got start=%0b fl=%0b exp 0 1", mcu_start, flush_idex); end
    step();
    checks++; if (mcu_busy !== 1'b0) begin errors++; $display("FAIL fl_nobusy got %0b exp 0", mcu_busy); end
    step();
    ex_branch_taken = 0;
    #1;
    checks++; if (flush_ifid !== 1'b1) begin errors++; $display("FAIL fl_reload got %0b exp 1", flush_ifid); end
    step();
    #1;
    checks++; if (flush_ifid !== 1'b0 || mcu_start !== 1'b1) begin errors++; $display("FAIL fl_end got fl=%0b start=%0b exp 0 1", flush_ifid, mcu_start); end
    step();
    idle_in();
    ex_branch_taken = 1;
    #1;
    checks++; if (mcu_busy !== 1'b1) begin errors++; $display("FAIL fl_keeps_op got %0b exp 1", mcu_busy); end
    ex_branch_taken = 0;
    mcu_done = 1;
    step();
    idle_in();
    step();
  endtask

  task automatic test_reg0();
    do_reset();
    issue_mcu(4'd0);
    #1;
    checks++; if (mcu_start !== 1'b1) begin errors++; $display("FAIL r0_start got %0b exp 1", mcu_start); end
    step();
    idle_in();
    id_valid = 1; id_rs = 4'd0; id_rs_used = 1; id_rt = 4'd0; id_rt_used = 1; id_regwrite = 1; id_rd = 4'd0;
    #1;
    checks++; if (mcu_busy !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL r0_pending got busy=%0b bub=%0b exp 1 0", mcu_busy, idex_bubble); end
    mcu_done = 1;
    step();
    mcu_done = 0;
    idex_memread = 1; idex_rd = 4'd0;
    #1;
    checks++; if (idex_bubble !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL r0_load got bub=%0b pc=%0b exp 0 1", idex_bubble, pc_write); end
    idle_in();
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_mcu(4'd4);
    step();
    idle_in();
    id_valid = 1; id_rs = 4'd4; id_rs_used = 1;
    step();
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL rm_pre_cnt got %0d exp 1", stall_cycles); end
    reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (mcu_busy !== 1'b0 || mcu_rd !== 4'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL rm_cleared got busy=%0b rd=%0d cnt=%0d exp 0 0 0", mcu_busy, mcu_rd, stall_cycles); end
    mcu_done = 1; id_regwrite = 1; id_rd = 4'd4;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rm_r4 got %0b exp 0", idex_bubble); end
    step();
    idle_in();
    mcu_done = 1;
    issue_mcu(4'd5);
    #1;
    checks++; if (mcu_start !== 1'b1) begin errors++; $display("FAIL rm_issue got %0b exp 1", mcu_start); end
    step();
    idle_in();
    checks++; if (mcu_busy !== 1'b1 || mcu_rd !== 4'd5) begin errors++; $display("FAIL rm_busy got busy=%0b rd=%0d exp 1 5", mcu_busy, mcu_rd); end
    mcu_done = 1;
    step();
    idle_in();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(4'd2);
    for (int i = 0; i < 5; i++) step();
    idle_in();
    #1;
    checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL sat_wide got %0d exp 5", stall_cycles); end
    checks++; if (stall_cycles_2 !== 2'd3) begin errors++; $display("FAIL sat_narrow got %0d exp 3", stall_cycles_2); end
    step();
  endtask

  initial begin
    idle_in();
    reset = 1;
    test_reset();
    test_load_use();
    test_mcu_raw();
    test_struct_waw();
    test_flush();
    test_reg0();
    test_reset_midop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
